// File: rtl/bypass_interlock.sv
// Operand bypass and load-use interlock: tracks in-flight destinations for DEPTH
// post-decode stages, forwards the youngest ready result and stalls ID otherwise.
module bypass_interlock #(
    parameter int DATA_W     = 16,
    parameter int REG_AW     = 4,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter bit ZERO_REG   = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [REG_AW-1:0]       id_rd,
    input  logic                    id_wen,
    input  logic                    id_is_load,
    input  logic                    flush,
    input  logic [REG_AW-1:0]       src_s,
    input  logic [REG_AW-1:0]       src_m,
    input  logic                    use_s,
    input  logic                    use_m,
    input  logic [DATA_W-1:0]       rf_s,
    input  logic [DATA_W-1:0]       rf_m,
    input  logic [DEPTH*DATA_W-1:0] stage_data,
    output logic [DATA_W-1:0]       op_s,
    output logic [DATA_W-1:0]       op_m,
    output logic                    stall,
    output logic [CNT_W-1:0]        stall_count,
    output logic [DEPTH-1:0]        dbg_valid
);

    // Stage indices never exceed 8, so a 4-bit ready-stage field covers every legal DEPTH.
    localparam int          SW       = 4;
    localparam logic [SW-1:0] LOAD_RDY = SW'(LOAD_STAGE);

    logic [DEPTH-1:0]  r_valid;
    logic [REG_AW-1:0] r_rd  [DEPTH];
    logic [SW-1:0]     r_rdy [DEPTH];
    logic [CNT_W-1:0]  r_stall_count;

    logic [DEPTH-1:0]  w_ready;
    logic              w_push;
    logic              w_hazard [2];
    logic [DATA_W-1:0] w_op     [2];
    logic [REG_AW-1:0] w_src    [2];
    logic              w_use    [2];
    logic [DATA_W-1:0] w_rf     [2];

    assign w_src[0] = src_s;
    assign w_src[1] = src_m;
    assign w_use[0] = use_s;
    assign w_use[1] = use_m;
    assign w_rf[0]  = rf_s;
    assign w_rf[1]  = rf_m;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ready
        assign w_ready[i] = (SW'(i) >= r_rdy[i]);
    end

    for (genvar g = 0; g < 2; g++) begin : g_lookup
        logic              w_hit;
        logic              w_hit_rdy;
        logic [DATA_W-1:0] w_fwd;
        logic              w_zero;

        assign w_zero = ZERO_REG && (w_src[g] == '0);

        // Scan oldest to youngest so the lowest matching stage is the one left standing.
        // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
        always_comb begin
            w_hit     = 1'b0;
            w_hit_rdy = 1'b0;
            w_fwd     = '0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (r_valid[i] && (r_rd[i] == w_src[g])) begin
                    w_hit     = 1'b1;
                    w_hit_rdy = w_ready[i];
                    w_fwd     = stage_data[i*DATA_W +: DATA_W];
                end
            end
        end

        always_comb begin
            w_hazard[g] = 1'b0;
            w_op[g]     = w_rf[g];
            if (w_hit && w_use[g] && !w_zero) begin
                if (w_hit_rdy) w_op[g] = w_fwd;
                else           w_hazard[g] = 1'b1;
            end
        end
    end

    assign op_s  = w_op[0];
    assign op_m  = w_op[1];
    assign stall = id_valid && !flush && (w_hazard[0] || w_hazard[1]);

    assign w_push = id_valid && id_wen && !flush && !stall
                    && !(ZERO_REG && (id_rd == '0));

    // NOTE: sequential state is written with <= so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            r_valid[0] <= w_push;
            for (int i = 1; i < DEPTH; i++) r_valid[i] <= r_valid[i-1];
        end
    end

    // NOTE: payload fields carry no reset; the valid bits alone decide whether they matter.
    always_ff @(posedge clk) begin
        r_rd[0]  <= id_rd;
        r_rdy[0] <= id_is_load ? LOAD_RDY : '0;
        for (int i = 1; i < DEPTH; i++) begin
            r_rd[i]  <= r_rd[i-1];
            r_rdy[i] <= r_rdy[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                              r_stall_count <= '0;
        else if (stall && !(&r_stall_count))  r_stall_count <= r_stall_count + 1'b1;
    end

    assign stall_count = r_stall_count;
    assign dbg_valid   = r_valid;

endmodule

// File: tb/tb_bypass_interlock.sv
// Directed self-checking bench: default instance plus a ZERO_REG=1, CNT_W=4 instance.
module tb_bypass_interlock;

    logic        clk = 1'b0;
    logic        rst;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    // Default-parameter instance
    logic        id_valid, id_wen, id_is_load, flush, use_s, use_m;
    logic [3:0]  id_rd, src_s, src_m;
    logic [15:0] rf_s, rf_m, op_s, op_m, stall_count;
    logic [47:0] stage_data;
    logic        stall;
    logic [2:0]  dbg_valid;

    bypass_interlock u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd(id_rd), .id_wen(id_wen),
        .id_is_load(id_is_load), .flush(flush), .src_s(src_s), .src_m(src_m),
        .use_s(use_s), .use_m(use_m), .rf_s(rf_s), .rf_m(rf_m),
        .stage_data(stage_data), .op_s(op_s), .op_m(op_m), .stall(stall),
        .stall_count(stall_count), .dbg_valid(dbg_valid)
    );

    // ZERO_REG=1, 4-bit counter instance
    logic        z_id_valid, z_id_wen, z_id_is_load, z_flush, z_use_s, z_use_m;
    logic [3:0]  z_id_rd, z_src_s, z_src_m, z_stall_count;
    logic [15:0] z_rf_s, z_rf_m, z_op_s, z_op_m;
    logic [47:0] z_stage_data;
    logic        z_stall;
    logic [2:0]  z_dbg_valid;

    bypass_interlock #(.ZERO_REG(1'b1), .CNT_W(4)) u_zdut (
        .clk(clk), .rst(rst), .id_valid(z_id_valid), .id_rd(z_id_rd), .id_wen(z_id_wen),
        .id_is_load(z_id_is_load), .flush(z_flush), .src_s(z_src_s), .src_m(z_src_m),
        .use_s(z_use_s), .use_m(z_use_m), .rf_s(z_rf_s), .rf_m(z_rf_m),
        .stage_data(z_stage_data), .op_s(z_op_s), .op_m(z_op_m), .stall(z_stall),
        .stall_count(z_stall_count), .dbg_valid(z_dbg_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [3:0] rd, input logic wen, input logic ld);
        id_valid = 1'b1; id_rd = rd; id_wen = wen; id_is_load = ld;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_wen = 1'b0; id_is_load = 1'b0; flush = 1'b0;
        use_s = 1'b0; use_m = 1'b0;
    endtask

    initial begin
        idle();
        id_rd = 4'd0; src_s = 4'd0; src_m = 4'd0;
        rf_s = 16'h1111; rf_m = 16'h2222;
        z_id_valid = 1'b0; z_id_wen = 1'b0; z_id_is_load = 1'b0; z_flush = 1'b0;
        z_use_s = 1'b0; z_use_m = 1'b0; z_id_rd = 4'd0; z_src_s = 4'd0; z_src_m = 4'd0;
        z_rf_s = 16'h5555; z_rf_m = 16'h6666; z_stage_data = '0;

        // Reset with a live, writing instruction at ID and all-ones results
        rst = 1'b1;
        issue(4'd7, 1'b1, 1'b0);
        src_s = 4'd7; use_s = 1'b1;
        stage_data = '1;
        tick();
        tick();
        rst = 1'b0;
        id_wen = 1'b0;
        #1;
        chk("rst_dbg_valid", 32'(dbg_valid), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_op_s", 32'(op_s), 32'h1111);
        chk("rst_stall_count", 32'(stall_count), 32'h0);

        // ALU chain: rd=3 then consume from stage 0
        idle();
        issue(4'd3, 1'b1, 1'b0);
        tick();
        issue(4'd8, 1'b0, 1'b0);
        src_s = 4'd3; use_s = 1'b1;
        stage_data = {16'h0000, 16'h0000, 16'h1234};
        #1;
        chk("alu_op_s", 32'(op_s), 32'h1234);
        chk("alu_stall", 32'(stall), 32'h0);
        chk("alu_dbg_valid", 32'(dbg_valid), 32'h1);
        tick();

        // Youngest wins: rd=5 twice in a row
        idle();
        issue(4'd5, 1'b1, 1'b0);
        tick();
        tick();
        issue(4'd8, 1'b0, 1'b0);
        src_m = 4'd5; use_m = 1'b1;
        src_s = 4'd3; use_s = 1'b1;
        stage_data = {16'hCCCC, 16'hBBBB, 16'hAAAA};
        #1;
        chk("young_op_m", 32'(op_m), 32'hAAAA);
        chk("young_dbg_valid", 32'(dbg_valid), 32'h3);
        chk("retired_op_s", 32'(op_s), 32'h1111);
        tick();

        // Drain the pipe
        idle();
        tick(); tick(); tick();
        chk("drain_dbg_valid", 32'(dbg_valid), 32'h0);

        // Load-use: load rd=2 followed by a dependent writer rd=6
        issue(4'd2, 1'b1, 1'b1);
        tick();
        issue(4'd6, 1'b1, 1'b0);
        id_is_load = 1'b0;
        src_s = 4'd2; use_s = 1'b1;
        stage_data = {16'h0000, 16'h00FF, 16'h1234};
        #1;
        chk("lu_stall_1", 32'(stall), 32'h1);
        chk("lu_count_0", 32'(stall_count), 32'h0);
        tick();
        chk("lu_stall_2", 32'(stall), 32'h0);
        chk("lu_op_s", 32'(op_s), 32'h00FF);
        chk("lu_count_1", 32'(stall_count), 32'h1);
        tick();
        chk("lu_dbg_valid", 32'(dbg_valid), 32'h5);

        // Same source on both operands, one load hazard -> one stall cycle
        idle();
        issue(4'd9, 1'b1, 1'b1);
        tick();
        issue(4'd8, 1'b0, 1'b0);
        id_is_load = 1'b0;
        src_s = 4'd9; src_m = 4'd9; use_s = 1'b1; use_m = 1'b1;
        #1;
        chk("dual_stall_1", 32'(stall), 32'h1);
        tick();
        chk("dual_stall_2", 32'(stall), 32'h0);
        chk("dual_count", 32'(stall_count), 32'h2);

        // Flush coincident with a hazard
        idle();
        issue(4'd10, 1'b1, 1'b1);
        tick();
        issue(4'd11, 1'b1, 1'b0);
        id_is_load = 1'b0;
        src_s = 4'd10; use_s = 1'b1; flush = 1'b1;
        #1;
        chk("fh_stall", 32'(stall), 32'h0);
        tick();
        chk("fh_count", 32'(stall_count), 32'h2);
        chk("fh_dbg_valid", 32'(dbg_valid), 32'h2);

        // Flushed load rd=4 is never tracked
        idle();
        issue(4'd4, 1'b1, 1'b1);
        flush = 1'b1;
        tick();
        idle();
        issue(4'd8, 1'b0, 1'b0);
        src_s = 4'd4; use_s = 1'b1; rf_s = 16'h4444;
        #1;
        chk("flush_stall", 32'(stall), 32'h0);
        chk("flush_op_s", 32'(op_s), 32'h4444);
        tick();

        // ZERO_REG=0: register 0 is tracked and forwarded like any other
        idle();
        issue(4'd0, 1'b1, 1'b0);
        tick();
        issue(4'd8, 1'b0, 1'b0);
        src_s = 4'd0; use_s = 1'b1;
        stage_data = {16'h0000, 16'h0000, 16'h0BAD};
        #1;
        chk("r0_fwd_op_s", 32'(op_s), 32'h0BAD);
        tick();

        // Reset asserted while a stall is pending
        idle();
        issue(4'd1, 1'b1, 1'b1);
        tick();
        issue(4'd8, 1'b0, 1'b0);
        id_is_load = 1'b0;
        src_s = 4'd1; use_s = 1'b1;
        #1;
        chk("rms_stall_before", 32'(stall), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rms_stall_after", 32'(stall), 32'h0);
        chk("rms_dbg_valid", 32'(dbg_valid), 32'h0);
        chk("rms_count", 32'(stall_count), 32'h0);
        idle();

        // ZERO_REG=1 instance: rd=0 is never tracked
        z_id_valid = 1'b1; z_id_wen = 1'b1; z_id_rd = 4'd0; z_id_is_load = 1'b0;
        tick();
        z_id_wen = 1'b0;
        z_src_s = 4'd0; z_use_s = 1'b1;
        z_stage_data = {16'h0000, 16'h0000, 16'hDEAD};
        #1;
        chk("z_dbg_valid", 32'(z_dbg_valid), 32'h0);
        chk("z_op_s", 32'(z_op_s), 32'h5555);
        chk("z_stall", 32'(z_stall), 32'h0);
        tick();
        z_use_s = 1'b0;
        z_id_wen = 1'b1; z_id_is_load = 1'b1; z_id_rd = 4'd0;
        tick();
        z_id_wen = 1'b0; z_id_is_load = 1'b0;
        z_src_m = 4'd0; z_use_m = 1'b1;
        #1;
        chk("z_load_r0_stall", 32'(z_stall), 32'h0);
        chk("z_load_r0_op_m", 32'(z_op_m), 32'h6666);
        tick();
        z_use_m = 1'b0;

        // Saturation: 20 load-use pairs, one stall each
        for (int k = 0; k < 20; k++) begin
            z_id_valid = 1'b1; z_id_wen = 1'b1; z_id_is_load = 1'b1; z_id_rd = 4'd1;
            z_use_s = 1'b0;
            tick();
            z_id_wen = 1'b0; z_id_is_load = 1'b0;
            z_src_s = 4'd1; z_use_s = 1'b1;
            #1;
            if (k == 0) chk("sat_first_stall", 32'(z_stall), 32'h1);
            tick();
            if (k == 2)  chk("sat_count_3", 32'(z_stall_count), 32'h3);
            if (k == 14) chk("sat_count_15", 32'(z_stall_count), 32'hF);
        end
        chk("sat_count_final", 32'(z_stall_count), 32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
